// File: rtl/producer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : producer_arbiter
//  Description : Collects words from two producers (fibonacci and timer)
//                into per-source holding registers, arbitrates them
//                round-robin into a single FIFO write port, and sequences
//                start / back-pressure / stop-and-drain through a small FSM.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst                   clock, asynchronous active-high reset
//    start_f, start_t, stop     single-cycle command pulses
//    f_valid/f_data             fibonacci producer word
//    t_valid/t_data             timer producer word
//    buffer_full                FIFO write side full (blocks grants)
//    buffer_empty, data_2_valid FIFO read side idle indicators (drain exit)
//    f_en, t_en                 producer enables
//    wr_en, wr_data, src        registered FIFO write strobe, word, source
//    busy                       FSM not idle
//    drain_done                 one-cycle pulse on return to idle after stop
//    drop_cnt                   saturating count of discarded words
// ============================================================================
module producer_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_f,
    input  logic        start_t,
    input  logic        stop,
    input  logic        f_valid,
    input  logic [15:0] f_data,
    input  logic        t_valid,
    input  logic [15:0] t_data,
    input  logic        buffer_full,
    input  logic        buffer_empty,
    input  logic        data_2_valid,
    output logic        f_en,
    output logic        t_en,
    output logic        wr_en,
    output logic [15:0] wr_data,
    output logic [1:0]  src,
    output logic        busy,
    output logic        drain_done,
    output logic [7:0]  drop_cnt
);

    localparam logic [1:0] C_SRC_NONE = 2'b00;
    localparam logic [1:0] C_SRC_FIB  = 2'b10;
    localparam logic [1:0] C_SRC_TMR  = 2'b01;
    localparam logic [7:0] C_DROP_MAX = 8'd255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        f_act_q, f_act_d;
    logic        t_act_q, t_act_d;
    logic        f_hold_valid_q, f_hold_valid_d;
    logic [15:0] f_hold_data_q, f_hold_data_d;
    logic        t_hold_valid_q, t_hold_valid_d;
    logic [15:0] t_hold_data_q, t_hold_data_d;
    // 0: fibonacci has priority at the next contention, 1: timer has it
    logic        rr_q, rr_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic [1:0]  src_q, src_d;
    logic        drain_done_q, drain_done_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    logic        w_grant_ok;
    logic        w_contention;
    logic        w_grant_f;
    logic        w_grant_t;
    logic        w_f_free;
    logic        w_t_free;
    logic        w_drop_f;
    logic        w_drop_t;
    logic [8:0]  w_drop_sum;

    // ------------------------------------------------------------------
    // Arbitration: only RUN and DRAIN may write, and never while full.
    // The round-robin pointer moves only on a real contention, pointing
    // at that contention's loser.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_ok   = ((state_q == RUN) || (state_q == DRAIN)) && !buffer_full;
        w_contention = w_grant_ok && f_hold_valid_q && t_hold_valid_q;
        w_grant_f    = w_grant_ok && f_hold_valid_q && (!t_hold_valid_q || !rr_q);
        w_grant_t    = w_grant_ok && t_hold_valid_q && (!f_hold_valid_q ||  rr_q);
    end

    // A holding register can take a new word if it is empty now or is
    // being granted at this same edge.
    always_comb begin
        w_f_free   = !f_hold_valid_q || w_grant_f;
        w_t_free   = !t_hold_valid_q || w_grant_t;
        w_drop_f   = f_valid && !w_f_free;
        w_drop_t   = t_valid && !w_t_free;
        w_drop_sum = {1'b0, drop_cnt_q} + {8'd0, w_drop_f} + {8'd0, w_drop_t};
    end

    // ------------------------------------------------------------------
    // Datapath next-state: holding registers, write port, drop counter
    // ------------------------------------------------------------------
    always_comb begin
        f_hold_valid_d = f_hold_valid_q;
        f_hold_data_d  = f_hold_data_q;
        t_hold_valid_d = t_hold_valid_q;
        t_hold_data_d  = t_hold_data_q;
        rr_d           = rr_q;
        wr_en_d        = 1'b0;
        wr_data_d      = wr_data_q;
        src_d          = C_SRC_NONE;
        drop_cnt_d     = drop_cnt_q;

        if (f_valid && w_f_free) begin
            f_hold_valid_d = 1'b1;
            f_hold_data_d  = f_data;
        end else if (w_grant_f) begin
            f_hold_valid_d = 1'b0;
        end

        if (t_valid && w_t_free) begin
            t_hold_valid_d = 1'b1;
            t_hold_data_d  = t_data;
        end else if (w_grant_t) begin
            t_hold_valid_d = 1'b0;
        end

        if (w_contention) begin
            rr_d = w_grant_f;
        end

        if (w_grant_f) begin
            wr_en_d   = 1'b1;
            wr_data_d = f_hold_data_q;
            src_d     = C_SRC_FIB;
        end else if (w_grant_t) begin
            wr_en_d   = 1'b1;
            wr_data_d = t_hold_data_q;
            src_d     = C_SRC_TMR;
        end

        // Both sources can drop in one cycle, so add and clamp.
        if (w_drop_sum > {1'b0, C_DROP_MAX}) begin
            drop_cnt_d = C_DROP_MAX;
        end else begin
            drop_cnt_d = w_drop_sum[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and activity flags. Stop outranks start and
    // back-pressure; starts are ignored while draining.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        f_act_d      = f_act_q;
        t_act_d      = t_act_q;
        drain_done_d = 1'b0;

        if (state_q != DRAIN) begin
            if (start_f) f_act_d = 1'b1;
            if (start_t) t_act_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start_f || start_t) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = DRAIN;
                    f_act_d = 1'b0;
                    t_act_d = 1'b0;
                end else if (buffer_full) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (stop) begin
                    state_d = DRAIN;
                    f_act_d = 1'b0;
                    t_act_d = 1'b0;
                end else if (!buffer_full) begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (!f_hold_valid_q && !t_hold_valid_q && buffer_empty && !data_2_valid) begin
                    state_d      = IDLE;
                    drain_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            f_act_q        <= 1'b0;
            t_act_q        <= 1'b0;
            f_hold_valid_q <= 1'b0;
            f_hold_data_q  <= 16'd0;
            t_hold_valid_q <= 1'b0;
            t_hold_data_q  <= 16'd0;
            rr_q           <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_data_q      <= 16'd0;
            src_q          <= C_SRC_NONE;
            drain_done_q   <= 1'b0;
            drop_cnt_q     <= 8'd0;
        end else begin
            state_q        <= state_d;
            f_act_q        <= f_act_d;
            t_act_q        <= t_act_d;
            f_hold_valid_q <= f_hold_valid_d;
            f_hold_data_q  <= f_hold_data_d;
            t_hold_valid_q <= t_hold_valid_d;
            t_hold_data_q  <= t_hold_data_d;
            rr_q           <= rr_d;
            wr_en_q        <= wr_en_d;
            wr_data_q      <= wr_data_d;
            src_q          <= src_d;
            drain_done_q   <= drain_done_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    // Enables are combinational so a producer stops the moment its
    // holding register fills or the FIFO reports full.
    assign f_en       = f_act_q && (state_q == RUN) && !f_hold_valid_q && !buffer_full;
    assign t_en       = t_act_q && (state_q == RUN) && !t_hold_valid_q && !buffer_full;
    assign busy       = (state_q != IDLE);
    assign wr_en      = wr_en_q;
    assign wr_data    = wr_data_q;
    assign src        = src_q;
    assign drain_done = drain_done_q;
    assign drop_cnt   = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_producer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_producer_arbiter
//  Description : Directed bench for producer_arbiter: single-word latency,
//                dual-source alternation, round-robin contention, WAIT
//                back-pressure, drop saturation, stop/drain, async reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_producer_arbiter;

    logic        clk;
    logic        rst;
    logic        start_f, start_t, stop;
    logic        f_valid, t_valid;
    logic [15:0] f_data, t_data;
    logic        buffer_full, buffer_empty, data_2_valid;
    logic        f_en, t_en, wr_en, busy, drain_done;
    logic [15:0] wr_data;
    logic [1:0]  src;
    logic [7:0]  drop_cnt;

    int errors = 0;
    int checks = 0;

    producer_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .start_f      (start_f),
        .start_t      (start_t),
        .stop         (stop),
        .f_valid      (f_valid),
        .f_data       (f_data),
        .t_valid      (t_valid),
        .t_data       (t_data),
        .buffer_full  (buffer_full),
        .buffer_empty (buffer_empty),
        .data_2_valid (data_2_valid),
        .f_en         (f_en),
        .t_en         (t_en),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .src          (src),
        .busy         (busy),
        .drain_done   (drain_done),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [1:0] s, input logic [15:0] d);
        chk({tag, ".wr_en"},   32'(wr_en),   32'(en));
        chk({tag, ".src"},     32'(src),     32'(s));
        chk({tag, ".wr_data"}, 32'(wr_data), 32'(d));
    endtask

    initial begin
        rst = 1'b1;
        start_f = 0; start_t = 0; stop = 0;
        f_valid = 0; t_valid = 0; f_data = 16'h0; t_data = 16'h0;
        buffer_full = 0; buffer_empty = 1; data_2_valid = 0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk_wr("reset", 1'b0, 2'b00, 16'h0000);
        chk("reset.busy",       32'(busy),       0);
        chk("reset.drain_done", 32'(drain_done), 0);
        chk("reset.drop_cnt",   32'(drop_cnt),   0);
        chk("reset.f_en",       32'(f_en),       0);
        chk("reset.t_en",       32'(t_en),       0);
        rst = 1'b0;
        tick();
        chk("idle.busy", 32'(busy), 0);

        // ---------------- single fibonacci word ----------------
        start_f = 1; tick(); start_f = 0;
        chk("t1.busy", 32'(busy), 1);
        chk("t1.f_en", 32'(f_en), 1);
        chk("t1.t_en", 32'(t_en), 0);
        f_valid = 1; f_data = 16'h0005; tick(); f_valid = 0;   // edge k
        chk("t1.f_en_held", 32'(f_en), 0);
        chk("t1.no_wr_k", 32'(wr_en), 0);
        tick();                                                 // edge k+1
        chk_wr("t1.write", 1'b1, 2'b10, 16'h0005);
        tick();
        chk_wr("t1.after", 1'b0, 2'b00, 16'h0005);
        chk("t1.f_en_again", 32'(f_en), 1);
        stop = 1; tick(); stop = 0;
        chk("t1.drain.busy", 32'(busy), 1);
        chk("t1.drain.f_en", 32'(f_en), 0);
        tick();
        chk("t1.drain_done", 32'(drain_done), 1);
        chk("t1.idle.busy",  32'(busy), 0);
        tick();
        chk("t1.drain_done_pulse", 32'(drain_done), 0);

        // ---------------- both sources, alternating ----------------
        start_f = 1; start_t = 1; tick(); start_f = 0; start_t = 0;
        chk("t2.f_en", 32'(f_en), 1);
        chk("t2.t_en", 32'(t_en), 1);
        f_valid = 1; f_data = 16'hF000; t_valid = 1; t_data = 16'hA000;
        tick();
        chk("t2.e1.wr_en", 32'(wr_en), 0);
        chk("t2.e1.f_en",  32'(f_en), 0);
        chk("t2.e1.t_en",  32'(t_en), 0);
        f_valid = 0; t_valid = 0;
        tick();                         // first contention: fibonacci wins
        chk_wr("t2.e2", 1'b1, 2'b10, 16'hF000);
        chk("t2.e2.f_en", 32'(f_en), 1);
        f_valid = 1; f_data = 16'hF001;
        tick(); f_valid = 0;
        chk_wr("t2.e3", 1'b1, 2'b01, 16'hA000);
        chk("t2.e3.t_en", 32'(t_en), 1);
        t_valid = 1; t_data = 16'hA001;
        tick(); t_valid = 0;
        chk_wr("t2.e4", 1'b1, 2'b10, 16'hF001);
        tick();
        chk_wr("t2.e5", 1'b1, 2'b01, 16'hA001);
        chk("t2.drop_cnt", 32'(drop_cnt), 0);

        // ---------------- second contention: timer lost last, wins now ----------------
        f_valid = 1; f_data = 16'hF002; t_valid = 1; t_data = 16'hA002;
        tick(); f_valid = 0; t_valid = 0;
        chk("rr.load.wr_en", 32'(wr_en), 0);
        tick();
        chk_wr("rr.first", 1'b1, 2'b01, 16'hA002);
        tick();
        chk_wr("rr.second", 1'b1, 2'b10, 16'hF002);
        tick();
        chk_wr("rr.idle", 1'b0, 2'b00, 16'hF002);

        // ---------------- back-pressure ----------------
        f_valid = 1; f_data = 16'hF003; tick(); f_valid = 0;
        buffer_full = 1; tick();        // RUN -> WAIT, no grant
        chk("t3.wait.wr_en", 32'(wr_en), 0);
        chk("t3.wait.f_en",  32'(f_en), 0);
        chk("t3.wait.t_en",  32'(t_en), 0);
        chk("t3.wait.busy",  32'(busy), 1);
        tick();
        chk("t3.wait2.wr_en", 32'(wr_en), 0);
        buffer_full = 0; tick();        // WAIT -> RUN, still no grant
        chk("t3.run.wr_en", 32'(wr_en), 0);
        chk("t3.run.t_en",  32'(t_en), 1);
        chk("t3.run.f_en",  32'(f_en), 0);
        tick();
        chk_wr("t3.release", 1'b1, 2'b10, 16'hF003);

        // ---------------- drop saturation ----------------
        f_valid = 1; f_data = 16'hF004; tick();
        buffer_full = 1; f_data = 16'hBAD0;
        tick();
        chk("t4.drop1", 32'(drop_cnt), 1);
        for (int i = 0; i < 254; i++) tick();
        chk("t4.drop255", 32'(drop_cnt), 255);
        for (int i = 0; i < 45; i++) tick();
        chk("t4.saturated", 32'(drop_cnt), 255);
        chk("t4.wr_en", 32'(wr_en), 0);
        f_valid = 0;

        // ---------------- stop with a held word ----------------
        buffer_full = 0; buffer_empty = 0; stop = 1;
        tick(); stop = 0;               // WAIT -> DRAIN
        chk("t5.drain.busy",  32'(busy), 1);
        chk("t5.drain.wr_en", 32'(wr_en), 0);
        start_t = 1;
        tick(); start_t = 0;            // held word flushed
        chk_wr("t5.flush", 1'b1, 2'b10, 16'hF004);
        chk("t5.t_en_ignored", 32'(t_en), 0);
        tick();
        chk("t5.hold.busy", 32'(busy), 1);
        chk("t5.hold.drain_done", 32'(drain_done), 0);
        buffer_empty = 1; data_2_valid = 1;
        tick();
        chk("t5.d2v.busy", 32'(busy), 1);
        chk("t5.d2v.drain_done", 32'(drain_done), 0);
        data_2_valid = 0;
        tick();
        chk("t5.drain_done", 32'(drain_done), 1);
        chk("t5.idle.busy",  32'(busy), 0);
        tick();
        chk("t5.pulse_end", 32'(drain_done), 0);
        chk("t5.still_idle", 32'(busy), 0);
        chk("t5.drop_kept", 32'(drop_cnt), 255);

        // ---------------- async reset mid-run ----------------
        start_f = 1; start_t = 1; tick(); start_f = 0; start_t = 0;
        f_valid = 1; f_data = 16'h1111; t_valid = 1; t_data = 16'h2222;
        tick(); f_valid = 0; t_valid = 0;
        chk("t6.f_held", 32'(f_en), 0);
        rst = 1; #1;
        chk_wr("t6.rst", 1'b0, 2'b00, 16'h0000);
        chk("t6.rst.busy",       32'(busy),       0);
        chk("t6.rst.f_en",       32'(f_en),       0);
        chk("t6.rst.t_en",       32'(t_en),       0);
        chk("t6.rst.drain_done", 32'(drain_done), 0);
        chk("t6.rst.drop_cnt",   32'(drop_cnt),   0);
        tick(); rst = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6.no_wr", 32'(wr_en), 0);
        end
        chk("t6.busy_after", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
